seven_segment_scanner: RTL and testbench

//   Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.

---
 rtl/seven_segment_pkg.sv | 47 ++++
 rtl/seven_segment_decoder.sv | 12 +
 rtl/seven_segment_scanner.sv | 158 +++++++++++++++
 tb/tb_seven_segment_scanner.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared 7-segment glyph constants and the hex-to-segment decode function.
// Glyphs are active-high, bit order gfedcba (bit0 = a).
package seven_segment_pkg;

  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;
  localparam logic [6:0] SEG_OFF = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational nibble-to-segment decoder, active-high gfedcba.
// Kept as its own module so other display paths can share it.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit 7-segment driver with shadow/active value registers,
// leading-zero blanking, an anti-ghost blank window and frame-aligned updates.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic                    enable_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic          INV        = (ACTIVE_LOW != 0);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seven_segment_scanner: NUM_DIGITS must be 1..8");
  end
  if (REFRESH_DIV < 2) begin : g_bad_refresh_div
    $error("seven_segment_scanner: REFRESH_DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
    $error("seven_segment_scanner: BLANK_CYCLES must be 0..REFRESH_DIV-1");
  end

  logic [PW-1:0]         presc;
  logic [IW-1:0]         idx;
  logic                  terminal;
  logic                  wrap;

  logic [VW-1:0]         shadow_value;
  logic [NUM_DIGITS-1:0] shadow_dp;
  logic [VW-1:0]         active_value;
  logic [NUM_DIGITS-1:0] active_dp;
  logic                  pending;

  logic                  in_window;
  logic                  lit;
  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  blank_digit;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign terminal = (presc == PRESC_LAST);
  assign wrap     = terminal && (idx == IDX_LAST);

  // Slot prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (terminal) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Loads land in the shadow register; active only changes on the frame wrap,
  // and a load coinciding with the wrap bypasses the shadow entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      active_value <= '0;
      active_dp    <= '0;
      pending      <= 1'b0;
    end else begin
      if (load_i) begin
        shadow_value <= value_i;
        shadow_dp    <= dp_i;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (load_i) begin
          active_value <= value_i;
          active_dp    <= dp_i;
        end else if (pending) begin
          active_value <= shadow_value;
          active_dp    <= shadow_dp;
        end
      end else if (load_i) begin
        pending <= 1'b1;
      end
    end
  end

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_window = 1'b1;
  end else begin : g_blank
    assign in_window = (presc >= PW'(BLANK_CYCLES));
  end

  assign lit        = in_window && enable_i;
  assign cur_nibble = active_value[{idx, 2'b00} +: 4];

  seven_segment_decoder u_decoder (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // Digit k is a leading zero when it and every digit above it are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (active_value[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run && (k != 0);
    end
  end

  assign blank_digit = blank_lz_i && lz_mask[idx];

  always_comb begin
    seg_next = (lit && !blank_digit) ? dec_seg : SEG_OFF;
    dp_next  = lit && active_dp[idx];
    an_next  = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      an_next[k] = lit && (idx == IW'(k));
    end
  end

  // Pin polarity is applied only here, so everything upstream is active-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o   <= {7{INV}};
      dp_o    <= INV;
      an_o    <= {NUM_DIGITS{INV}};
      frame_o <= 1'b0;
    end else begin
      seg_o   <= seg_next ^ {7{INV}};
      dp_o    <= dp_next ^ INV;
      an_o    <= an_next ^ {NUM_DIGITS{INV}};
      frame_o <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, ACTIVE_LOW=1; expected pin values are hand-derived.
module tb_seven_segment_scanner;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        blank_lz_i;
  logic        enable_i;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (8),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .load_i     (load_i),
    .blank_lz_i (blank_lz_i),
    .enable_i   (enable_i),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .an_o       (an_o),
    .frame_o    (frame_o)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // n counts clock edges since the last observed frame pulse (or reset release).
  task automatic goto(input int target);
    while (n < target) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value_i = v;
    dp_i    = d;
    load_i  = 1'b1;
    @(negedge clk);
    n++;
    load_i  = 1'b0;
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    while (frame_o !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("wait_frame_seen", 32'(frame_o), 32'd1);
    n = 0;
  endtask

  // Digit k is blank at edges 8k+1..8k+2 after a frame pulse and lit at 8k+3..8k+8.
  task automatic check_digit(input int k, input logic [6:0] seg_exp, input logic dp_exp);
    logic [3:0] an_exp;
    an_exp = 4'hF ^ (4'h1 << k);
    goto(8*k + 1);
    check($sformatf("d%0d_blank_an", k), 32'(an_o), 32'hF);
    check($sformatf("d%0d_blank_seg", k), 32'(seg_o), 32'h7F);
    check($sformatf("d%0d_blank_dp", k), 32'(dp_o), 32'd1);
    goto(8*k + 4);
    check($sformatf("d%0d_an", k), 32'(an_o), 32'(an_exp));
    check($sformatf("d%0d_seg", k), 32'(seg_o), 32'(seg_exp));
    check($sformatf("d%0d_dp", k), 32'(dp_o), 32'(dp_exp));
  endtask

  task automatic frame_step();
    goto(31);
    check("frame_low_before_wrap", 32'(frame_o), 32'd0);
    goto(32);
    check("frame_pulse", 32'(frame_o), 32'd1);
    n = 0;
  endtask

  initial begin
    rst        = 1'b1;
    value_i    = '0;
    dp_i       = '0;
    load_i     = 1'b0;
    blank_lz_i = 1'b0;
    enable_i   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'd1);
    check("rst_frame", 32'(frame_o), 32'd0);
    rst = 1'b0;

    // basic scan of 12AF
    do_load(16'h12AF, 4'b0000);
    wait_frame();
    check_digit(0, 7'h0E, 1'b1);
    check_digit(1, 7'h08, 1'b1);
    check_digit(2, 7'h24, 1'b1);
    check_digit(3, 7'h79, 1'b1);
    frame_step();

    // tear-free: 1111 then 2222 inside one frame; frame still shows 12AF
    do_load(16'h1111, 4'b0000);
    check_digit(0, 7'h0E, 1'b1);
    check_digit(1, 7'h08, 1'b1);
    goto(14);
    do_load(16'h2222, 4'b0000);
    check_digit(2, 7'h24, 1'b1);
    check_digit(3, 7'h79, 1'b1);
    frame_step();
    check_digit(0, 7'h24, 1'b1);
    check_digit(1, 7'h24, 1'b1);
    check_digit(2, 7'h24, 1'b1);
    check_digit(3, 7'h24, 1'b1);

    // wrap collision: load in the terminal cycle of digit 3
    goto(31);
    check("collide_frame_low", 32'(frame_o), 32'd0);
    do_load(16'h789B, 4'b0001);
    check("collide_frame_pulse", 32'(frame_o), 32'd1);
    n = 0;
    check_digit(0, 7'h03, 1'b0);
    check_digit(1, 7'h10, 1'b1);
    check_digit(2, 7'h00, 1'b1);
    check_digit(3, 7'h78, 1'b1);

    // leading-zero blanking of 0050 with dp on digit 3
    blank_lz_i = 1'b1;
    do_load(16'h0050, 4'b1000);
    frame_step();
    check_digit(0, 7'h40, 1'b1);
    check_digit(1, 7'h12, 1'b1);
    check_digit(2, 7'h7F, 1'b1);
    check_digit(3, 7'h7F, 1'b0);
    do_load(16'h0000, 4'b0000);
    frame_step();
    check_digit(0, 7'h40, 1'b1);
    check_digit(1, 7'h7F, 1'b1);
    check_digit(2, 7'h7F, 1'b1);
    check_digit(3, 7'h7F, 1'b1);
    frame_step();

    // display disabled for 20 cycles across a frame wrap
    goto(20);
    enable_i = 1'b0;
    for (int i = 21; i <= 40; i++) begin
      goto(i);
      check($sformatf("dis_an_%0d", i), 32'(an_o), 32'hF);
      check($sformatf("dis_frame_%0d", i), 32'(frame_o), (i == 32) ? 32'd1 : 32'd0);
    end
    enable_i = 1'b1;
    goto(43);
    check("reenable_an", 32'(an_o), 32'hD);
    goto(63);
    check("reenable_frame_low", 32'(frame_o), 32'd0);
    goto(64);
    check("reenable_frame_pulse", 32'(frame_o), 32'd1);
    n = 0;

    // asynchronous reset mid-slot, then restart from digit 0 with active=0
    goto(12);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_an", 32'(an_o), 32'hF);
    check("mid_rst_seg", 32'(seg_o), 32'h7F);
    check("mid_rst_dp", 32'(dp_o), 32'd1);
    check("mid_rst_frame", 32'(frame_o), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    blank_lz_i = 1'b0;
    n          = 0;
    check_digit(0, 7'h40, 1'b1);
    check_digit(1, 7'h40, 1'b1);
    goto(31);
    check("post_rst_frame_low", 32'(frame_o), 32'd0);
    goto(32);
    check("post_rst_frame_pulse", 32'(frame_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
